// File: rtl/lp_cntr_pkg.sv
// rtl/lp_cntr_pkg.sv - shared constants and types for the low-power counter family
package lp_cntr_pkg;

    // Terminal-flag timing modes
    localparam int LP_TRM_COMB = 0;
    localparam int LP_TRM_REG  = 1;

    // Legal counter width bounds
    localparam int LP_CNTR_MIN_W = 2;
    localparam int LP_CNTR_MAX_W = 64;

    // Kind of update the count register takes on a clock edge
    typedef enum logic [1:0] {
        UPD_HOLD = 2'd0,
        UPD_LOAD = 2'd1,
        UPD_STEP = 2'd2
    } lp_upd_e;

endpackage

// File: rtl/lp_cntr_nxt.sv
// rtl/lp_cntr_nxt.sv - next-count and update-enable for the down counter
module lp_cntr_nxt
    import lp_cntr_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             ld_n,
    input  logic             enable,
    input  logic [width-1:0] ld_count,
    input  logic [width-1:0] count,
    output logic [width-1:0] next_count,
    output logic             upd
);

    lp_upd_e sel;

    // Priority: load beats enable, otherwise hold
    always_comb begin
        sel = UPD_HOLD;
        if (!ld_n) begin
            sel = UPD_LOAD;
        end else if (enable) begin
            sel = UPD_STEP;
        end
    end

    // Value the count register takes; on hold it equals the current count
    always_comb begin
        next_count = count;
        case (sel)
            UPD_LOAD: next_count = ld_count;
            UPD_STEP: next_count = count - width'(1);
            default:  next_count = count;
        endcase
    end

    assign upd = (sel != UPD_HOLD);

endmodule

// File: rtl/lp_cntr_dn_df.sv
// rtl/lp_cntr_dn_df.sv - loadable down counter with dynamic terminal-value flag
module lp_cntr_dn_df
    import lp_cntr_pkg::*;
#(
    parameter int width      = 8,
    parameter int reg_trmcnt = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ld_n,
    input  logic [width-1:0] ld_count,
    input  logic [width-1:0] term_val,
    output logic [width-1:0] count,
    output logic             term_count_n
);

    generate
        if (width < LP_CNTR_MIN_W || width > LP_CNTR_MAX_W) begin : g_bad_width
            $fatal(1, "lp_cntr_dn_df: width out of range");
        end
        if (reg_trmcnt != LP_TRM_COMB && reg_trmcnt != LP_TRM_REG) begin : g_bad_mode
            $fatal(1, "lp_cntr_dn_df: reg_trmcnt must be 0 or 1");
        end
    endgenerate

    logic [width-1:0] count_q;
    logic [width-1:0] next_count;
    logic             upd;

    lp_cntr_nxt #(
        .width(width)
    ) u_nxt (
        .ld_n      (ld_n),
        .enable    (enable),
        .ld_count  (ld_count),
        .count     (count_q),
        .next_count(next_count),
        .upd       (upd)
    );

    // Count register is written only on load or decrement, so idle cycles do not toggle it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (upd) begin
            count_q <= next_count;
        end
    end

    assign count = count_q;

    generate
        if (reg_trmcnt == LP_TRM_REG) begin : g_flag_reg
            logic flag_q;

            // Flag compares against the incoming count so it lines up with count; written every cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    flag_q <= 1'b1;
                end else begin
                    flag_q <= ~(next_count == term_val);
                end
            end

            assign term_count_n = flag_q;
        end else begin : g_flag_comb
            assign term_count_n = ~(count_q == term_val);
        end
    endgenerate

endmodule

// File: tb/tb_lp_cntr_dn_df.sv
// tb/tb_lp_cntr_dn_df.sv - self-checking bench for lp_cntr_dn_df in both flag modes
module tb_lp_cntr_dn_df;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ld_n;
    logic [7:0] ld_count;
    logic [7:0] term_val;
    logic [7:0] count_c;
    logic [7:0] count_r;
    logic       tcn_c;
    logic       tcn_r;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: count as plain integer 0..255, registered flag as remembered bit
    int m_count;
    bit m_flag_r;

    always #5 clk = ~clk;

    lp_cntr_dn_df #(.width(8), .reg_trmcnt(0)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .ld_n(ld_n),
        .ld_count(ld_count), .term_val(term_val),
        .count(count_c), .term_count_n(tcn_c)
    );

    lp_cntr_dn_df #(.width(8), .reg_trmcnt(1)) dut_r (
        .clk(clk), .rst(rst), .enable(enable), .ld_n(ld_n),
        .ld_count(ld_count), .term_val(term_val),
        .count(count_r), .term_count_n(tcn_r)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Combinational flag: low exactly when the current count equals term_val
    task automatic check_comb_flag(input string tag);
        check(tag, 64'(tcn_c), 64'((m_count == int'(term_val)) ? 0 : 1));
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count_c"}, 64'(count_c), 64'(m_count));
        check({tag, "_count_r"}, 64'(count_r), 64'(m_count));
        check_comb_flag({tag, "_flag_c"});
        check({tag, "_flag_r"}, 64'(tcn_r), 64'(m_flag_r));
    endtask

    // One clock: apply the behavioural rules, then compare shortly after the edge
    task automatic tick(input string tag);
        @(posedge clk);
        if (!ld_n)
            m_count = int'(ld_count);
        else if (enable)
            m_count = (m_count + 255) % 256;
        m_flag_r = (m_count != int'(term_val));
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset state and wrap from zero
        rst = 1'b1; enable = 1'b0; ld_n = 1'b1; ld_count = 8'h00; term_val = 8'h05;
        m_count = 0; m_flag_r = 1'b1;
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        tick("wrap");
        check("wrap_ff", 64'(count_c), 64'hFF);

        // Load then decrement through the terminal value
        ld_n = 1'b0; ld_count = 8'h0A; enable = 1'b0; term_val = 8'h07;
        tick("load0a");
        ld_n = 1'b1; enable = 1'b1;
        for (int i = 0; i < 4; i++) tick("dec");
        check("at06", 64'(count_r), 64'h06);
        check("flag_r_06", 64'(tcn_r), 64'h1);

        // Registered flag must fall exactly on the cycle count shows 07
        ld_n = 1'b0; ld_count = 8'h09; enable = 1'b1;
        tick("reload09");
        ld_n = 1'b1;
        tick("dec08");
        check("flag_r_08", 64'(tcn_r), 64'h1);
        tick("dec07");
        check("flag_r_07", 64'(tcn_r), 64'h0);
        check("flag_c_07", 64'(tcn_c), 64'h0);

        // Dynamic term_val during hold
        ld_n = 1'b0; ld_count = 8'h30; enable = 1'b0; term_val = 8'h31;
        tick("load30");
        ld_n = 1'b1;
        tick("hold30");
        term_val = 8'h30;
        #1;
        check("dyn_comb_imm", 64'(tcn_c), 64'h0);
        check("dyn_reg_late", 64'(tcn_r), 64'h1);
        tick("dyn_after");
        check("dyn_reg_now", 64'(tcn_r), 64'h0);

        // Load beats enable, then long hold
        ld_n = 1'b0; enable = 1'b1; ld_count = 8'h55; term_val = 8'h00;
        tick("prio");
        check("prio_55", 64'(count_c), 64'h55);
        ld_n = 1'b1; enable = 1'b0;
        for (int i = 0; i < 10; i++) tick("hold55");

        // Load value equal to term_val flags on the same cycle in both modes
        ld_n = 1'b0; ld_count = 8'h44; term_val = 8'h44;
        tick("ld_eq_term");
        check("ld_eq_flag_r", 64'(tcn_r), 64'h0);
        ld_n = 1'b1;

        // Async reset in the middle of counting
        ld_n = 1'b0; ld_count = 8'h24; enable = 1'b1; term_val = 8'h10;
        tick("load24");
        ld_n = 1'b1;
        tick("dec23");
        tick("dec22");
        #1;
        rst = 1'b1;
        #2;
        m_count = 0; m_flag_r = 1'b1;
        check_all("async_rst");
        rst = 1'b0;
        tick("resume");
        check("resume_ff", 64'(count_r), 64'hFF);

        // Random traffic; term_val usually near the count so matches occur
        for (int i = 0; i < 300; i++) begin
            ld_n     = ($urandom_range(0, 7) != 0);
            enable   = ($urandom_range(0, 3) != 0);
            ld_count = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                term_val = 8'($urandom);
            else
                term_val = 8'((m_count + 256 - $urandom_range(0, 3)) % 256);
            #1;
            check_comb_flag("rnd_pre");
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
